i2c_target_regif: RTL and testbench

I2C target (responder) with a 7-bit device address and a 16-bit register pointer. It converts bus write and read transactions into single-cycle strobes on a local byte-wide register port. It is the counterpart of the ToF I2C initiator: it serves as the on-board ToF register-map emulator and as the bench responder for initiator regression. It samples SCL/SDA oversampled in the system clock domain and never drives SCL (no clock stretching).

---
 rtl/i2c_target_regif.sv | 270 +++++++++++++++++++++++++++
 tb/tb_i2c_target_regif.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regif.sv
// I2C target with 7-bit address and 16-bit register pointer, mapped to a byte-wide strobe port.
// Optional build macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchronizer.
module i2c_target_regif #(
    parameter logic [6:0] SLAVE_ADDR = 7'h29
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SDA_out,
    output logic        SDA_t,
    output logic [15:0] reg_addr,
    output logic [7:0]  wr_data,
    output logic        wr_strobe,
    output logic        rd_strobe,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        error_out
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [1:0] pad_in;
    logic [1:0] line_cond;

    assign pad_in = {SDA_in, SCL_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0] sync_reg;
            always_ff @(posedge clock) begin
                if (reset) sync_reg <= 2'b11;
                else       sync_reg <= {sync_reg[0], pad_in[gi]};
            end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
            logic [1:0] hist_reg;
            logic       maj_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    hist_reg <= 2'b11;
                    maj_reg  <= 1'b1;
                end else begin
                    hist_reg <= {hist_reg[0], sync_reg[1]};
                    maj_reg  <= (sync_reg[1] & hist_reg[0]) | (sync_reg[1] & hist_reg[1])
                              | (hist_reg[0] & hist_reg[1]);
                end
            end
            assign line_cond[gi] = maj_reg;
`else
            assign line_cond[gi] = sync_reg[1];
`endif
        end
    endgenerate

    logic scl, sda, scl_prev_reg, sda_prev_reg;
    logic scl_rise, scl_fall, start_det, stop_det, last_bit;

    assign scl       = line_cond[0];
    assign sda       = line_cond[1];
    assign scl_rise  = scl & ~scl_prev_reg;
    assign scl_fall  = ~scl & scl_prev_reg;
    assign start_det = scl & scl_prev_reg & sda_prev_reg & ~sda;
    assign stop_det  = scl & scl_prev_reg & ~sda_prev_reg & sda;

    state_t      state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic        bit_open_reg, bit_open_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  tx_reg, tx_next;
    logic [15:0] ptr_reg, ptr_next;
    logic        rw_reg, rw_next;
    logic        ack_phase_reg, ack_phase_next;
    logic [1:0]  rd_dly_reg, rd_dly_next;
    logic        sda_t_reg, sda_t_next;
    logic [15:0] reg_addr_reg, reg_addr_next;
    logic [7:0]  wr_data_reg, wr_data_next;
    logic        wr_strobe_reg, wr_strobe_next;
    logic        rd_strobe_reg, rd_strobe_next;
    logic        busy_reg, busy_next;
    logic        error_reg, error_next;
    logic [7:0]  byte_in;

    assign byte_in  = {shift_reg[6:0], sda};
    assign last_bit = scl_rise && (bit_cnt_reg == 3'd7);

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_prev_reg  <= 1'b1;
            sda_prev_reg  <= 1'b1;
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            bit_open_reg  <= 1'b0;
            shift_reg     <= 8'h00;
            tx_reg        <= 8'hFF;
            ptr_reg       <= 16'h0000;
            rw_reg        <= 1'b0;
            ack_phase_reg <= 1'b0;
            rd_dly_reg    <= 2'b00;
            sda_t_reg     <= 1'b1;
            reg_addr_reg  <= 16'h0000;
            wr_data_reg   <= 8'h00;
            wr_strobe_reg <= 1'b0;
            rd_strobe_reg <= 1'b0;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            scl_prev_reg  <= scl;
            sda_prev_reg  <= sda;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            bit_open_reg  <= bit_open_next;
            shift_reg     <= shift_next;
            tx_reg        <= tx_next;
            ptr_reg       <= ptr_next;
            rw_reg        <= rw_next;
            ack_phase_reg <= ack_phase_next;
            rd_dly_reg    <= rd_dly_next;
            sda_t_reg     <= sda_t_next;
            reg_addr_reg  <= reg_addr_next;
            wr_data_reg   <= wr_data_next;
            wr_strobe_reg <= wr_strobe_next;
            rd_strobe_reg <= rd_strobe_next;
            busy_reg      <= busy_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        bit_open_next  = bit_open_reg;
        shift_next     = shift_reg;
        tx_next        = tx_reg;
        ptr_next       = ptr_reg;
        rw_next        = rw_reg;
        ack_phase_next = ack_phase_reg;
        rd_dly_next    = {rd_dly_reg[0], rd_strobe_reg};
        sda_t_next     = sda_t_reg;
        reg_addr_next  = reg_addr_reg;
        wr_data_next   = wr_data_reg;
        wr_strobe_next = 1'b0;
        rd_strobe_next = 1'b0;
        busy_next      = busy_reg;
        error_next     = 1'b0;

        if (rd_dly_reg[1]) tx_next = rd_data;

        if (start_det || stop_det) begin
            // A lone rise with no following fall is the condition's own SCL-high phase, not a data bit.
            error_next     = (bit_cnt_reg != 3'd0) && !((bit_cnt_reg == 3'd1) && bit_open_reg);
            state_next     = start_det ? ADDR : IDLE;
            bit_cnt_next   = 3'd0;
            bit_open_next  = 1'b0;
            ack_phase_next = 1'b0;
            sda_t_next     = 1'b1;
            if (stop_det) busy_next = 1'b0;
        end else begin
            if (scl_rise) bit_open_next = 1'b1;
            if (scl_fall) bit_open_next = 1'b0;
            case (state_reg)
                ADDR, REG_HI, REG_LO, WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                    if (last_bit) begin
                        if (state_reg == ADDR) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_next = ADDR_ACK;
                                rw_next    = byte_in[0];
                                busy_next  = 1'b1;
                                if (byte_in[0]) begin
                                    rd_strobe_next = 1'b1;
                                    reg_addr_next  = ptr_reg;
                                end
                            end else begin
                                state_next = WAIT_STOP;
                                busy_next  = 1'b0;
                            end
                        end else if (state_reg == REG_HI) begin
                            ptr_next[15:8] = byte_in;
                            state_next     = REG_HI_ACK;
                        end else if (state_reg == REG_LO) begin
                            ptr_next[7:0] = byte_in;
                            state_next    = REG_LO_ACK;
                        end else begin
                            wr_data_next   = byte_in;
                            reg_addr_next  = ptr_reg;
                            wr_strobe_next = 1'b1;
                            ptr_next       = ptr_reg + 16'd1;
                            state_next     = WR_ACK;
                        end
                    end
                end
                ADDR_ACK, REG_HI_ACK, REG_LO_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            sda_t_next     = 1'b0;
                            ack_phase_next = 1'b1;
                        end else begin
                            ack_phase_next = 1'b0;
                            sda_t_next     = 1'b1;
                            if (state_reg == ADDR_ACK) begin
                                if (rw_reg) begin
                                    state_next = RD_DATA;
                                    sda_t_next = tx_reg[7];
                                    tx_next    = {tx_reg[6:0], 1'b1};
                                end else begin
                                    state_next = REG_HI;
                                end
                            end else if (state_reg == REG_HI_ACK) begin
                                state_next = REG_LO;
                            end else begin
                                state_next = WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            ptr_next       = ptr_reg + 16'd1;
                            state_next     = RD_ACK;
                            ack_phase_next = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_t_next = tx_reg[7];
                        tx_next    = {tx_reg[6:0], 1'b1};
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            sda_t_next = 1'b1;
                        end else begin
                            ack_phase_next = 1'b0;
                            state_next     = RD_DATA;
                            sda_t_next     = tx_reg[7];
                            tx_next        = {tx_reg[6:0], 1'b1};
                        end
                    end else if (scl_rise && !ack_phase_reg) begin
                        if (!sda) begin
                            ack_phase_next = 1'b1;
                            rd_strobe_next = 1'b1;
                            reg_addr_next  = ptr_reg;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA_out   = sda_t_reg;
    assign SDA_t     = sda_t_reg;
    assign reg_addr  = reg_addr_reg;
    assign wr_data   = wr_data_reg;
    assign wr_strobe = wr_strobe_reg;
    assign rd_strobe = rd_strobe_reg;
    assign busy      = busy_reg;
    assign error_out = error_reg;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: bit-banged I2C initiator with a strobe scoreboard and monitor.
module tb_i2c_target_regif;

    localparam int Q = 8;  // clocks per quarter SCL period

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        SCL_in, SDA_in, SDA_out, SDA_t;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data, rd_data;
    logic        wr_strobe, rd_strobe, busy, error_out;

    int checks = 0;
    int errors = 0;
    logic [23:0] wr_q[$];
    logic [15:0] rd_q[$];
    int exp_err = 0;
    logic watch_t = 1'b0;
    int driven_cnt = 0;

    always #5 clock = ~clock;

    assign SCL_in  = scl_m;
    assign SDA_in  = sda_m & (SDA_t | SDA_out);
    assign rd_data = (reg_addr == 16'h0010) ? 8'h3C :
                     (reg_addr == 16'h0011) ? 8'hC3 : 8'h0F;

    i2c_target_regif dut (
        .clock(clock), .reset(reset), .SCL_in(SCL_in), .SDA_in(SDA_in),
        .SDA_out(SDA_out), .SDA_t(SDA_t), .reg_addr(reg_addr), .wr_data(wr_data),
        .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .rd_data(rd_data),
        .busy(busy), .error_out(error_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or error pulse.
    initial begin
        logic [23:0] e;
        logic [15:0] r;
        forever begin
            @(negedge clock);
            if (watch_t && !SDA_t) driven_cnt++;
            if (!reset && wr_strobe) begin
                if (wr_q.size() == 0) chk("unexpected_wr_strobe", {8'h0, reg_addr, wr_data}, 32'hFFFFFFFF);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_strobe_addr_data", {8'h0, reg_addr, wr_data}, {8'h0, e});
                end
            end
            if (!reset && rd_strobe) begin
                if (rd_q.size() == 0) chk("unexpected_rd_strobe", {16'h0, reg_addr}, 32'hFFFFFFFF);
                else begin
                    r = rd_q.pop_front();
                    chk("rd_strobe_addr", {16'h0, reg_addr}, {16'h0, r});
                end
            end
            if (!reset && error_out) begin
                if (exp_err == 0) chk("unexpected_error_out", 32'd1, 32'd0);
                else begin
                    exp_err--;
                    chk("error_out_pulse", 32'd1, 32'd1);
                end
            end
        end
    end

    task automatic wq(); repeat (Q) @(negedge clock); endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; wq();
        scl_m = 1'b1; wq();
        if (glitch) begin
            scl_m = 1'b0; @(negedge clock);
            scl_m = 1'b1;
        end
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = SDA_in; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] v, input int glitch_at, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_at);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic master_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        send_bit(master_ack, 1'b0);
    endtask

    task automatic write_seq(input string name, input logic [7:0] v);
        logic ack;
        write_byte(v, -1, ack);
        chk(name, {31'h0, ack}, 32'd0);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] v;

        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_SDA_out", {31'h0, SDA_out}, 32'd1);
        chk("reset_SDA_t", {31'h0, SDA_t}, 32'd1);
        chk("reset_reg_addr", {16'h0, reg_addr}, 32'd0);
        chk("reset_wr_data", {24'h0, wr_data}, 32'd0);
        chk("reset_strobes_busy_err", {28'h0, wr_strobe, rd_strobe, busy, error_out}, 32'd0);
        wq();

        // Register write of two bytes at 0x010F
        wr_q.push_back({16'h010F, 8'hAA});
        wr_q.push_back({16'h0110, 8'h55});
        i2c_start();
        write_seq("wr_ack_addr", 8'h52);
        write_seq("wr_ack_ptr_hi", 8'h01);
        write_seq("wr_ack_ptr_lo", 8'h0F);
        write_seq("wr_ack_data0", 8'hAA);
        write_seq("wr_ack_data1", 8'h55);
        chk("busy_during_write", {31'h0, busy}, 32'd1);
        i2c_stop();
        wq();
        chk("busy_after_stop", {31'h0, busy}, 32'd0);

        // Random read from 0x0010 with repeated start
        rd_q.push_back(16'h0010);
        rd_q.push_back(16'h0011);
        i2c_start();
        write_seq("rd_ack_waddr", 8'h52);
        write_seq("rd_ack_ptr_hi", 8'h00);
        write_seq("rd_ack_ptr_lo", 8'h10);
        i2c_rstart();
        write_seq("rd_ack_raddr", 8'h53);
        read_byte(v, 1'b0);
        chk("rd_byte0", {24'h0, v}, 32'h3C);
        read_byte(v, 1'b1);
        chk("rd_byte1", {24'h0, v}, 32'hC3);
        i2c_stop();
        wq();

        // Address mismatch: never drives SDA
        driven_cnt = 0;
        watch_t = 1'b1;
        i2c_start();
        write_byte(8'h54, -1, ack);
        chk("mismatch_nack", {31'h0, ack}, 32'd1);
        chk("mismatch_busy", {31'h0, busy}, 32'd0);
        write_byte(8'h00, -1, ack);
        i2c_stop();
        wq();
        watch_t = 1'b0;
        chk("mismatch_sda_never_driven", driven_cnt, 32'd0);

        // Pointer wrap 0xFFFF -> 0x0000
        wr_q.push_back({16'hFFFF, 8'h11});
        wr_q.push_back({16'h0000, 8'h22});
        i2c_start();
        write_seq("wrap_ack_addr", 8'h52);
        write_seq("wrap_ack_hi", 8'hFF);
        write_seq("wrap_ack_lo", 8'hFF);
        write_seq("wrap_ack_d0", 8'h11);
        write_seq("wrap_ack_d1", 8'h22);
        i2c_stop();
        wq();

        // Abort: STOP after 4 data bits
        i2c_start();
        write_seq("abort_ack_addr", 8'h52);
        write_seq("abort_ack_hi", 8'h00);
        write_seq("abort_ack_lo", 8'h20);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        exp_err++;
        i2c_stop();
        wq();
        chk("abort_busy_low", {31'h0, busy}, 32'd0);

        // Reset mid-read from retained pointer 0x0020 (byte 0x0F)
        rd_q.push_back(16'h0020);
        i2c_start();
        write_seq("rst_ack_raddr", 8'h53);
        read_bit(b);
        chk("rst_rd_bit7", {31'h0, b}, 32'd0);
        chk("rst_sda_driven_before", {31'h0, SDA_t}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_sda_released", {31'h0, SDA_t}, 32'd1);
        reset = 1'b0;
        chk("rst_reg_addr", {16'h0, reg_addr}, 32'd0);
        sda_m = 1'b1; scl_m = 1'b1; wq(); wq();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        wr_q.push_back({16'h0030, 8'h5A});
        i2c_start();
        write_seq("glitch_ack_addr", 8'h52);
        write_seq("glitch_ack_hi", 8'h00);
        write_seq("glitch_ack_lo", 8'h30);
        write_byte(8'h5A, 3, ack);
        chk("glitch_ack_data", {31'h0, ack}, 32'd0);
        i2c_stop();
        wq();
`endif

        wq();
        chk("wr_queue_drained", wr_q.size(), 32'd0);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("errors_all_seen", exp_err, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
